// File: rtl/datapath_run_pkg.sv
// rtl/datapath_run_pkg.sv - state encoding and parameter helpers for the datapath run controller
package datapath_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int reset_cycles, input int run_cycles);
    return $clog2(max2(reset_cycles, run_cycles) + 1);
  endfunction

  function automatic bit params_ok(input int reset_cycles, input int run_cycles, input int depth);
    return (reset_cycles >= 1) && (run_cycles >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/datapath_run_ctrl_if.sv
// rtl/datapath_run_ctrl_if.sv - control, trace status and trace read signals of the run controller
interface datapath_run_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              Start;
  logic              CaptureOnChange;
  logic [DATA_W-1:0] ALUResult;
  logic              DpReset;
  logic              Running;
  logic              Done;
  logic              Overflow;
  logic [AW:0]       TraceCount;
  logic [AW-1:0]     RdAddr;
  logic [DATA_W-1:0] RdData;

  modport master (
    output Start, CaptureOnChange, ALUResult, RdAddr,
    input  DpReset, Running, Done, Overflow, TraceCount, RdData
  );

  modport slave (
    input  Start, CaptureOnChange, ALUResult, RdAddr,
    output DpReset, Running, Done, Overflow, TraceCount, RdData
  );
endinterface

// File: rtl/datapath_run_ctrl_trace_buffer.sv
// rtl/datapath_run_ctrl_trace_buffer.sv - simple dual-port trace RAM, registered write-first read
module trace_buffer #(
  parameter  int DATA_W      = 32,
  parameter  int TRACE_DEPTH = 32,
  localparam int AW          = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [TRACE_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    // Bypass so a read of the entry being written returns the new value
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/datapath_run_ctrl.sv
// rtl/datapath_run_ctrl.sv - reset/run sequencer for Datapath with ALUResult trace capture
module datapath_run_ctrl
  import datapath_run_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 3,
  parameter int RUN_CYCLES   = 19,
  parameter int TRACE_DEPTH  = 32
) (
  input logic               Clk,
  input logic               Reset,
  datapath_run_ctrl_if.slave bus
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = cnt_width(RESET_CYCLES, RUN_CYCLES);
  localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(TRACE_DEPTH);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

  if (!params_ok(RESET_CYCLES, RUN_CYCLES, TRACE_DEPTH)) begin : g_bad_params
    $error("datapath_run_ctrl: illegal RESET_CYCLES/RUN_CYCLES/TRACE_DEPTH");
  end

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              dp_reset_q, running_q, done_q, overflow_q, rd_valid_q;
  logic [AW:0]       count_q, count_next;
  logic [DATA_W-1:0] last_q, ram_rd_data;
  logic              start_ok, cap_event, wr_en, ovf_set, rd_valid_next;

  assign start_ok = bus.Start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt == RUN_LAST) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // cnt==0 in RUN marks the first run cycle, which always captures in change mode
  assign cap_event = (state == ST_RUN) &&
                     (!bus.CaptureOnChange || (cnt == '0) || (bus.ALUResult != last_q));
  assign wr_en     = cap_event && (count_q < DEPTH_V);
  assign ovf_set   = cap_event && (count_q == DEPTH_V);

  assign count_next    = start_ok ? '0 : count_q + {{AW{1'b0}}, wr_en};
  // Compare against the post-edge count so same-edge writes are readable
  assign rd_valid_next = ({1'b0, bus.RdAddr} < count_next);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dp_reset_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      last_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      dp_reset_q <= (state_next != ST_RUN);
      running_q  <= (state_next == ST_RUN);
      done_q     <= (state_next == ST_DONE);
      overflow_q <= start_ok ? 1'b0 : (overflow_q | ovf_set);
      count_q    <= count_next;
      if (start_ok) begin
        last_q <= '0;
      end else if (wr_en) begin
        last_q <= bus.ALUResult;
      end
      rd_valid_q <= rd_valid_next;
    end
  end

  trace_buffer #(
    .DATA_W      (DATA_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (Clk),
    .we      (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (bus.ALUResult),
    .rd_addr (bus.RdAddr),
    .rd_data (ram_rd_data)
  );

  assign bus.DpReset    = dp_reset_q;
  assign bus.Running    = running_q;
  assign bus.Done       = done_q;
  assign bus.Overflow   = overflow_q;
  assign bus.TraceCount = count_q;
  assign bus.RdData     = rd_valid_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// tb/tb_datapath_run_ctrl.sv - self-checking bench for datapath_run_ctrl (depth 32 and depth 8 instances)
module tb_datapath_run_ctrl;

  localparam int R  = 3;
  localparam int N  = 19;
  localparam int DA = 32;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] alu = '0;
  logic [4:0]  rd_addr = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] vals [N];
  bit          modes [N];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  bit          ovf_a, ovf_b;

  datapath_run_ctrl_if #(.DATA_W(32), .AW(5)) ifa ();
  datapath_run_ctrl_if #(.DATA_W(32), .AW(3)) ifb ();

  assign ifa.Start = start;
  assign ifa.CaptureOnChange = mode;
  assign ifa.ALUResult = alu;
  assign ifa.RdAddr = rd_addr;
  assign ifb.Start = start;
  assign ifb.CaptureOnChange = mode;
  assign ifb.ALUResult = alu;
  assign ifb.RdAddr = rd_addr[2:0];

  datapath_run_ctrl #(.DATA_W(32), .RESET_CYCLES(R), .RUN_CYCLES(N), .TRACE_DEPTH(DA)) dut_a (
    .Clk(clk), .Reset(rst_n), .bus(ifa)
  );
  datapath_run_ctrl #(.DATA_W(32), .RESET_CYCLES(R), .RUN_CYCLES(N), .TRACE_DEPTH(DB)) dut_b (
    .Clk(clk), .Reset(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  // Expected trace: list of captured values, no wrap, last value only moves on a stored capture
  task automatic build_model();
    logic [31:0] q [$];
    logic [31:0] last;
    bit ovf;
    int depth;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? DA : DB;
      q.delete();
      ovf = 0;
      last = '0;
      for (int j = 0; j < N; j++) begin
        if (!modes[j] || j == 0 || vals[j] != last) begin
          if (q.size() < depth) begin
            q.push_back(vals[j]);
            last = vals[j];
          end else begin
            ovf = 1;
          end
        end
      end
      if (d == 0) begin exp_a = q; ovf_a = ovf; end
      else        begin exp_b = q; ovf_b = ovf; end
    end
  endtask

  task automatic run_and_check(input string name, input bit glitch);
    bit in_run;
    logic [2:0] e;
    logic [31:0] ea, eb;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < R + N + 2; k++) begin
      in_run = (k >= R) && (k < R + N);
      e = {!in_run, in_run, (k >= R + N)};
      if (k == 0) begin
        checks++;
        if ({ifa.TraceCount, ifa.Overflow} !== 7'd0 || {ifb.TraceCount, ifb.Overflow} !== 5'd0) begin
          errors++;
          $display("FAIL %s start_clear: a cnt=%0d ovf=%b b cnt=%0d ovf=%b, need all 0",
                   name, ifa.TraceCount, ifa.Overflow, ifb.TraceCount, ifb.Overflow);
        end
      end
      checks++;
      if ({ifa.DpReset, ifa.Running, ifa.Done} !== e || {ifb.DpReset, ifb.Running, ifb.Done} !== e) begin
        errors++;
        $display("FAIL %s seq cyc%0d: a rst/run/done=%b b=%b, need %b", name, k,
                 {ifa.DpReset, ifa.Running, ifa.Done}, {ifb.DpReset, ifb.Running, ifb.Done}, e);
      end
      if (in_run) begin
        alu = vals[k - R];
        mode = modes[k - R];
      end
      start = glitch && (k == 1 || k == R + 5);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ifa.TraceCount !== 6'(exp_a.size()) || ifa.Overflow !== ovf_a) begin
      errors++;
      $display("FAIL %s count_a: cnt=%0d ovf=%b, need cnt=%0d ovf=%b",
               name, ifa.TraceCount, ifa.Overflow, exp_a.size(), ovf_a);
    end
    checks++;
    if (ifb.TraceCount !== 4'(exp_b.size()) || ifb.Overflow !== ovf_b) begin
      errors++;
      $display("FAIL %s count_b: cnt=%0d ovf=%b, need cnt=%0d ovf=%b",
               name, ifb.TraceCount, ifb.Overflow, exp_b.size(), ovf_b);
    end
    for (int a = 0; a < DA; a++) begin
      rd_addr = 5'(a);
      @(posedge clk);
      @(negedge clk);
      ea = (a < exp_a.size()) ? exp_a[a] : 32'd0;
      checks++;
      if (ifa.RdData !== ea) begin
        errors++;
        $display("FAIL %s read_a[%0d]: got %0h, need %0h", name, a, ifa.RdData, ea);
      end
      if (a < DB) begin
        eb = (a < exp_b.size()) ? exp_b[a] : 32'd0;
        checks++;
        if (ifb.RdData !== eb) begin
          errors++;
          $display("FAIL %s read_b[%0d]: got %0h, need %0h", name, a, ifb.RdData, eb);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if ({ifa.DpReset, ifa.Running, ifa.Done, ifa.Overflow} !== 4'b1000 || ifa.TraceCount !== 6'd0 ||
        ifa.RdData !== 32'd0 ||
        {ifb.DpReset, ifb.Running, ifb.Done, ifb.Overflow} !== 4'b1000 || ifb.TraceCount !== 4'd0 ||
        ifb.RdData !== 32'd0) begin
      errors++;
      $display("FAIL %s: a rst/run/done/ovf=%b cnt=%0d rd=%0h b=%b cnt=%0d rd=%0h, need 1000 0 0",
               name, {ifa.DpReset, ifa.Running, ifa.Done, ifa.Overflow}, ifa.TraceCount, ifa.RdData,
               {ifb.DpReset, ifb.Running, ifb.Done, ifb.Overflow}, ifb.TraceCount, ifb.RdData);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("idle_after_reset");
  endtask

  task automatic test_count();
    for (int j = 0; j < N; j++) begin vals[j] = 32'(100 + j); modes[j] = 0; end
    run_and_check("count", 1'b0);
    rd_addr = 5'd19;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifa.RdData !== 32'd0) begin
      errors++;
      $display("FAIL count rd19: got %0h, need 0", ifa.RdData);
    end
  endtask

  task automatic test_change();
    for (int j = 0; j < N; j++) begin
      vals[j] = (j < 6) ? 32'd5 : (j < 16) ? 32'd7 : 32'd5;
      modes[j] = 1;
    end
    run_and_check("change", 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < N; j++) begin vals[j] = $urandom; modes[j] = 0; end
    run_and_check("back_to_back", 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < N; j++) begin
        vals[j] = 32'($urandom_range(0, 3));
        modes[j] = 1'($urandom_range(0, 1));
      end
      run_and_check("random", 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    rd_addr = 5'd0;
    mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < R + 5; k++) begin
      if (k >= R) alu = 32'(200 + k);
      @(negedge clk);
    end
    checks++;
    if (ifa.Running !== 1'b1 || ifa.TraceCount !== 6'd5 || ifa.RdData !== 32'(200 + R)) begin
      errors++;
      $display("FAIL mid_run_pre: run=%b cnt=%0d rd=%0h, need 1 5 %0h",
               ifa.Running, ifa.TraceCount, ifa.RdData, 200 + R);
    end
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("idle_after_abort");
  endtask

  initial begin
    test_reset();
    test_count();
    test_change();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
